// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential-PC fetch unit with pipelined memory requests,
// an instruction buffer for decode, and branch redirect with stale-response drop.
module instr_fetch_queue #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int              MAX_OUTSTANDING = 2,
  parameter int              IBUF_DEPTH      = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] mem_req_addr,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  input  logic [XLEN-1:0] mem_rsp_data,
  input  logic            mem_rsp_valid,
  output logic            mem_rsp_ready,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(IBUF_DEPTH) + 1;
  localparam int PW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam logic [OW-1:0]   MAX_OUT = OW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0]   FULL    = CW'(IBUF_DEPTH);
  localparam logic [PW-1:0]   LAST    = PW'(IBUF_DEPTH - 1);
  localparam logic [XLEN-1:0] STEP    = XLEN'(4);

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
  } ibuf_entry_t;

  // Request channel registers
  logic            req_valid_q;
  logic [XLEN-1:0] req_addr_q;
  logic            rsp_ready_q;

  // Fetch bookkeeping
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   drop_cnt;
  logic            stale_req;

  // Instruction buffer
  ibuf_entry_t     ibuf [IBUF_DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  // Handshakes and next-state values
  logic            req_xfer;
  logic            rsp_xfer;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] target_pc;
  logic [OW-1:0]   out_next;
  logic [OW-1:0]   drop_next;
  logic            stale_next;
  logic [XLEN-1:0] fetch_pc_next;
  logic [XLEN-1:0] rsp_pc_next;
  logic [CW-1:0]   cnt_next;
  logic            issue;
  logic            req_valid_next;
  logic [XLEN-1:0] req_addr_next;

  assign req_xfer  = req_valid_q && mem_req_ready;
  assign rsp_xfer  = mem_rsp_valid && rsp_ready_q;
  assign pop       = instr_valid && instr_ready;
  // A response arriving in a redirect cycle belongs to the old path, so it
  // is never buffered; drop_cnt already accounts for it via out_next.
  assign push      = rsp_xfer && !redirect_valid && (drop_cnt == '0);
  assign target_pc = {redirect_pc[XLEN-1:2], 2'b00};

  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_rsp_ready = rsp_ready_q;
  assign instr_valid   = (count != '0);
  assign instr_data    = instr_valid ? ibuf[rd_ptr].data : '0;
  assign instr_pc      = instr_valid ? ibuf[rd_ptr].pc   : '0;

  // Next-cycle counters, PCs and the registered request-issue decision
  always_comb begin
    out_next = outstanding;
    if (req_xfer && !rsp_xfer)      out_next = outstanding + 1'b1;
    else if (!req_xfer && rsp_xfer) out_next = outstanding - 1'b1;

    drop_next = drop_cnt;
    if (redirect_valid) begin
      drop_next = out_next;
    end else begin
      if (rsp_xfer && (drop_cnt != '0)) drop_next = drop_next - 1'b1;
      if (req_xfer && stale_req)        drop_next = drop_next + 1'b1;
    end

    // A held request survives a redirect; it becomes stale and its response
    // is dropped once it finally transfers.
    stale_next = stale_req;
    if (redirect_valid) stale_next = req_valid_q && !req_xfer;
    else if (req_xfer)  stale_next = 1'b0;

    fetch_pc_next = fetch_pc;
    if (redirect_valid)             fetch_pc_next = target_pc;
    else if (req_xfer && !stale_req) fetch_pc_next = fetch_pc + STEP;

    rsp_pc_next = rsp_pc;
    if (redirect_valid) rsp_pc_next = target_pc;
    else if (push)      rsp_pc_next = rsp_pc + STEP;

    cnt_next = count;
    if (redirect_valid)     cnt_next = '0;
    else if (push && !pop)  cnt_next = count + 1'b1;
    else if (!push && pop)  cnt_next = count - 1'b1;

    // Credit rule: every in-flight request has a guaranteed buffer slot.
    issue = !stale_next && (out_next < MAX_OUT) &&
            ((32'(out_next) + 32'(cnt_next)) < 32'(IBUF_DEPTH));

    req_valid_next = req_valid_q;
    req_addr_next  = req_addr_q;
    if (req_valid_q && !req_xfer) begin
      req_valid_next = 1'b1;
    end else if (issue) begin
      req_valid_next = 1'b1;
      req_addr_next  = fetch_pc_next;
    end else begin
      req_valid_next = 1'b0;
    end
  end

  // Control state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_valid_q <= 1'b0;
      req_addr_q  <= RESET_PC;
      rsp_ready_q <= 1'b0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      stale_req   <= 1'b0;
      count       <= '0;
    end else begin
      req_valid_q <= req_valid_next;
      req_addr_q  <= req_addr_next;
      rsp_ready_q <= 1'b1;
      fetch_pc    <= fetch_pc_next;
      rsp_pc      <= rsp_pc_next;
      outstanding <= out_next;
      drop_cnt    <= drop_next;
      stale_req   <= stale_next;
      count       <= cnt_next;
    end
  end

  // Buffer pointers; a redirect flushes by rewinding both to zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
    end
  end

  // Buffer storage; contents are only visible while count is non-zero
  always_ff @(posedge clk) begin
    if (push) ibuf[wr_ptr] <= '{data: mem_rsp_data, pc: rsp_pc};
  end

  // The credit rule must make a push into a full buffer without a pop impossible
  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && !pop && (count == FULL)));
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: memory responder answers one cycle
// after each accepted request with addr ^ 32'hA5A5_0000.
module tb_instr_fetch_queue;

  localparam logic [31:0] K = 32'hA5A5_0000;
  localparam logic [31:0] NONE = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mem_req_addr;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_valid;
  logic        mem_rsp_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int n_tests = 0;
  int n_fail  = 0;
  logic rsp_en;
  logic [31:0] mq[$];
  logic [31:0] req_log[$];
  logic [31:0] ipc_log[$];
  logic [31:0] idat_log[$];
  int out_cnt = 0;
  int max_out = 0;

  always #5 clk = ~clk;

  instr_fetch_queue dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_addr(mem_req_addr), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .instr_data(instr_data), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] req_at(input int i);
    return (i < req_log.size()) ? req_log[i] : NONE;
  endfunction
  function automatic logic [31:0] ipc_at(input int i);
    return (i < ipc_log.size()) ? ipc_log[i] : NONE;
  endfunction
  function automatic logic [31:0] dat_at(input int i);
    return (i < idat_log.size()) ? idat_log[i] : NONE;
  endfunction

  task automatic clear_logs();
    req_log.delete();
    ipc_log.delete();
    idat_log.delete();
  endtask

  task automatic do_reset(input logic ir, input logic mr, input logic re);
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = ir;
    mem_req_ready = mr;
    rsp_en = re;
    repeat (2) @(negedge clk);
    clear_logs();
    reset = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  // Monitor: samples handshakes at the active edge (pre-edge values)
  initial forever begin
    @(posedge clk);
    if (reset) begin
      mq.delete();
      out_cnt = 0;
    end else begin
      if (mem_rsp_valid && mem_rsp_ready && mq.size() > 0) begin
        void'(mq.pop_front());
        out_cnt--;
      end
      if (mem_req_valid && mem_req_ready) begin
        mq.push_back(mem_req_addr);
        req_log.push_back(mem_req_addr);
        out_cnt++;
      end
      if (out_cnt > max_out) max_out = out_cnt;
      if (instr_valid && instr_ready) begin
        ipc_log.push_back(instr_pc);
        idat_log.push_back(instr_data);
      end
    end
  end

  // Memory responder: presents the oldest accepted request just after the edge
  initial begin
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && rsp_en && mq.size() > 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data = mq[0] ^ K;
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data = '0;
      end
    end
  end

  initial begin
    logic [31:0] head;
    bit found;
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b1;
    mem_req_ready = 1'b1;
    rsp_en = 1'b1;

    // Reset state, then first request one edge after release
    repeat (2) @(negedge clk);
    chk("rst_req_valid", 32'(mem_req_valid), 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_rsp_ready", 32'(mem_rsp_ready), 0);
    chk("rst_instr_valid", 32'(instr_valid), 0);
    chk("rst_instr_data", instr_data, 0);
    chk("rst_instr_pc", instr_pc, 0);
    clear_logs();
    reset = 1'b0;
    @(negedge clk);
    chk("rsp_ready_up", 32'(mem_rsp_ready), 1);
    chk("first_req_valid", 32'(mem_req_valid), 1);
    chk("first_req_addr", mem_req_addr, 0);

    // Streaming fetch
    repeat (20) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("stream_req%0d", i), req_at(i), 32'(4 * i));
      chk($sformatf("stream_pc%0d", i), ipc_at(i), 32'(4 * i));
      chk($sformatf("stream_dat%0d", i), dat_at(i), 32'(4 * i) ^ K);
    end

    // Decode stalled: exactly four requests fill the buffer
    do_reset(1'b0, 1'b1, 1'b1);
    repeat (12) @(negedge clk);
    chk("stall_req_cnt", 32'(req_log.size()), 4);
    chk("stall_req_valid", 32'(mem_req_valid), 0);
    chk("stall_instr_valid", 32'(instr_valid), 1);
    chk("stall_head_pc", instr_pc, 0);
    instr_ready = 1'b1;
    repeat (12) @(negedge clk);
    for (int i = 0; i < 6; i++)
      chk($sformatf("drain_pc%0d", i), ipc_at(i), 32'(4 * i));
    chk("resume_req", req_at(4), 32'h10);

    // Redirect with two responses outstanding
    do_reset(1'b1, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    chk("out2_req_valid", 32'(mem_req_valid), 0);
    redirect(32'h1002);
    chk("rd1_instr_valid", 32'(instr_valid), 0);
    clear_logs();
    rsp_en = 1'b1;
    repeat (10) @(negedge clk);
    chk("rd1_req0", req_at(0), 32'h1000);
    chk("rd1_pc0", ipc_at(0), 32'h1000);
    chk("rd1_dat0", dat_at(0), 32'h1000 ^ K);
    chk("rd1_pc1", ipc_at(1), 32'h1004);

    // Redirect coinciding with a decode handshake and an arriving response
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (instr_valid && mem_rsp_valid) found = 1;
      else @(negedge clk);
    end
    chk("rd2_setup_found", 32'(found), 1);
    head = instr_pc;
    redirect(32'h300);
    chk("rd2_instr_valid", 32'(instr_valid), 0);
    chk("rd2_last_pop", (ipc_log.size() > 0) ? ipc_log[$] : NONE, head);
    clear_logs();
    repeat (8) @(negedge clk);
    chk("rd2_pc0", ipc_at(0), 32'h300);
    chk("rd2_pc1", ipc_at(1), 32'h304);

    // Redirect near the top of the address space: low bits masked, PC wraps
    redirect(32'hFFFF_FFFB);
    clear_logs();
    repeat (10) @(negedge clk);
    chk("wrap_pc0", ipc_at(0), 32'hFFFF_FFF8);
    chk("wrap_pc1", ipc_at(1), 32'hFFFF_FFFC);
    chk("wrap_pc2", ipc_at(2), 32'h0);
    chk("wrap_dat2", dat_at(2), K);

    // Held request across a redirect
    do_reset(1'b1, 1'b1, 1'b1);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (req_log.size() >= 2) found = 1;
      else @(negedge clk);
    end
    chk("hold_setup_found", 32'(found), 1);
    mem_req_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("hold_valid", 32'(mem_req_valid), 1);
    chk("hold_addr", mem_req_addr, 32'h8);
    redirect(32'h200);
    clear_logs();
    chk("hold_addr_post_rd", mem_req_addr, 32'h8);
    repeat (2) @(negedge clk);
    chk("hold_addr_later", mem_req_addr, 32'h8);
    mem_req_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("hold_req0", req_at(0), 32'h8);
    chk("hold_req1", req_at(1), 32'h200);
    chk("hold_req2", req_at(2), 32'h204);
    chk("hold_pc0", ipc_at(0), 32'h200);
    chk("hold_dat0", dat_at(0), 32'h200 ^ K);

    // Asynchronous reset with a full buffer
    do_reset(1'b0, 1'b1, 1'b1);
    repeat (12) @(negedge clk);
    chk("full_instr_valid", 32'(instr_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_req_valid", 32'(mem_req_valid), 0);
    chk("arst_req_addr", mem_req_addr, 0);
    chk("arst_rsp_ready", 32'(mem_rsp_ready), 0);
    chk("arst_instr_valid", 32'(instr_valid), 0);
    chk("arst_instr_data", instr_data, 0);
    chk("arst_instr_pc", instr_pc, 0);
    @(negedge clk);
    clear_logs();
    instr_ready = 1'b1;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("restart_req0", req_at(0), 32'h0);
    chk("restart_pc0", ipc_at(0), 32'h0);
    chk("restart_dat0", dat_at(0), K);

    chk("max_out_le2", 32'(max_out <= 2), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
